note_scheduler: RTL



---
 rtl/note_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - timed note event FIFO and sequencer driving the DDS tuning word and gate
module note_scheduler #(
  parameter int TICK_DIV   = 100000,
  parameter int GAP_MS     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [31:0] note_word,
  input  logic [15:0] note_ms,
  input  logic        flush,
  output logic [31:0] tuning_word,
  output logic        gate,
  output logic        busy,
  output logic [2:0]  fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0]       FULL_CNT  = 3'(FIFO_DEPTH);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0]      GAP_TICKS = 16'(GAP_MS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
  state_t state, state_next;

  logic [47:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [2:0]       count_next;
  logic [PRE_W-1:0] presc;
  logic [15:0]      dur_cnt, gap_cnt;
  logic             tick, push, pop, load, note_end, gap_start;
  logic [31:0]      head_word;
  logic [15:0]      head_ms;

  assign tick      = (presc == PRE_LAST);
  assign push      = note_valid && note_ready && !flush;
  assign head_word = mem[rd_ptr][47:16];
  assign head_ms   = mem[rd_ptr][15:0];

  // Next state, pop/load strobes and next occupancy; flush overrides all of it.
  // With no gap configured a finished note falls back to IDLE, which gives the
  // single silent cycle between back-to-back notes.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    note_end   = 1'b0;
    gap_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != 3'd0) begin
          pop = 1'b1;
          if (head_ms != 16'd0) begin
            load       = 1'b1;
            state_next = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (tick && dur_cnt == 16'd1) begin
          note_end = 1'b1;
          if (GAP_MS == 0) begin
            state_next = S_IDLE;
          end else begin
            gap_start  = 1'b1;
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (tick && gap_cnt == 16'd1) begin
          state_next = S_IDLE;
          if (fifo_count != 3'd0) begin
            pop = 1'b1;
            if (head_ms != 16'd0) begin
              load       = 1'b1;
              state_next = S_PLAY;
            end
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      pop        = 1'b0;
      load       = 1'b0;
      note_end   = 1'b0;
      gap_start  = 1'b0;
    end
    count_next = fifo_count + {2'b00, push} - {2'b00, pop};
    if (flush) count_next = 3'd0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Event storage, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {note_word, note_ms};
  end

  // FIFO pointers, occupancy and the registered ready/busy flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 3'd0;
      note_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= count_next;
      note_ready <= (count_next != FULL_CNT);
      busy       <= (state_next != S_IDLE) || (count_next != 3'd0);
    end
  end

  // Tick prescaler, duration/gap counters and the tone outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc       <= '0;
      dur_cnt     <= 16'd0;
      gap_cnt     <= 16'd0;
      tuning_word <= 32'd0;
      gate        <= 1'b0;
    end else if (flush) begin
      presc       <= '0;
      tuning_word <= 32'd0;
      gate        <= 1'b0;
    end else begin
      if (load || tick) presc <= '0;
      else              presc <= presc + 1'b1;
      if (load) begin
        tuning_word <= head_word;
        gate        <= 1'b1;
      end else if (note_end) begin
        tuning_word <= 32'd0;
        gate        <= 1'b0;
      end
      if (load)                         dur_cnt <= head_ms;
      else if (state == S_PLAY && tick) dur_cnt <= dur_cnt - 16'd1;
      if (gap_start)                    gap_cnt <= GAP_TICKS;
      else if (state == S_GAP && tick)  gap_cnt <= gap_cnt - 16'd1;
    end
  end

endmodule
